dram_uart_dumper: RTL and testbench

- Reads a block of bytes out of data memory and transmits them serially, 8N1, on a UART TX line.
- Triggered after the processor raises end_process, so the result matrix written into DRAM can be read on a host.
- The processor writes DRAM; this block reads it back. It drives the DRAM address while busy; the top level muxes dm_addr onto the DRAM address when bus_own=1.

---
 rtl/dram_uart_dumper.sv | 163 ++++++++++++++++
 tb/tb_dram_uart_dumper.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_uart_dumper.sv
// dram_uart_dumper: reads COUNT bytes from DRAM starting at BASE_ADDR and sends
// them out as 8N1 UART frames, LSB first, one frame per byte.
//
// Ports:
//   i_clock    system clock
//   i_rst      synchronous active-high reset
//   i_start    dump request; a rising edge seen while idle starts one dump
//   i_dm_q     DRAM read data, valid RD_LAT cycles after o_dm_addr changes
//   o_dm_addr  DRAM read address (muxed onto the DRAM bus while o_bus_own=1)
//   o_bus_own  high while this block owns the DRAM address bus
//   o_uart_tx  serial output, idles high
//   o_busy     dump in progress
//   o_done     one-cycle pulse when a dump completes
module dram_uart_dumper #(
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [15:0] COUNT        = 16'd9,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter logic [1:0]  RD_LAT       = 2'd1
) (
    input  logic        i_clock,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_dm_q,
    output logic [15:0] o_dm_addr,
    output logic        o_bus_own,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_FIN
    } state_t;

    localparam logic [15:0] LAST_IDX  = COUNT - 16'd1;
    localparam logic [15:0] BIT_LAST  = CLKS_PER_BIT - 16'd1;
    localparam logic [1:0]  WAIT_LAST = RD_LAT - 2'd1;

    state_t      r_state;
    logic        r_start_d;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_bit_timer;
    logic [1:0]  r_wait_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shreg;

    logic        w_trigger;
    logic        w_bit_end;

    // Only a fresh rising edge observed in IDLE starts a dump; edges while busy are dropped.
    assign w_trigger = i_start & ~r_start_d & (r_state == S_IDLE);
    assign w_bit_end = (r_bit_timer == BIT_LAST);

    // Dump sequencer: address/readback, then start, 8 data, stop bit per byte.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_byte_cnt  <= 16'd0;
            r_bit_timer <= 16'd0;
            r_wait_cnt  <= 2'd0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'd0;
            o_dm_addr   <= BASE_ADDR;
            o_bus_own   <= 1'b0;
            o_uart_tx   <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            r_start_d <= i_start;
            o_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        if (COUNT == 16'd0) begin
                            o_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            o_dm_addr  <= BASE_ADDR;
                            r_byte_cnt <= 16'd0;
                            o_busy     <= 1'b1;
                            o_bus_own  <= 1'b1;
                            r_wait_cnt <= 2'd0;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                // Give the DRAM RD_LAT cycles to present data for the current address.
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                S_LOAD: begin
                    r_shreg     <= i_dm_q;
                    o_uart_tx   <= 1'b0;
                    r_bit_timer <= 16'd0;
                    r_state     <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_timer <= 16'd0;
                        o_uart_tx   <= r_shreg[0];
                        r_shreg     <= {1'b0, r_shreg[7:1]};
                        r_bit_idx   <= 3'd0;
                        r_state     <= S_DATA;
                    end else begin
                        r_bit_timer <= r_bit_timer + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bit_timer <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            o_uart_tx <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            o_uart_tx <= r_shreg[0];
                            r_shreg   <= {1'b0, r_shreg[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_timer <= r_bit_timer + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_bit_timer <= 16'd0;
                        if (r_byte_cnt == LAST_IDX) begin
                            o_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                            o_dm_addr  <= o_dm_addr + 16'd1;
                            r_wait_cnt <= 2'd0;
                            r_state    <= S_WAIT;
                        end
                    end else begin
                        r_bit_timer <= r_bit_timer + 16'd1;
                    end
                end
                S_FIN: begin
                    o_busy    <= 1'b0;
                    o_bus_own <= 1'b0;
                    o_dm_addr <= BASE_ADDR;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_uart_dumper.sv
// tb_dram_uart_dumper: four dumper instances with different BASE_ADDR/COUNT,
// each with its own DRAM model, checked every cycle against a closed-form
// timing model plus a UART byte decoder and literal expectations.
module tb_dram_uart_dumper;

    localparam int NI    = 4;
    localparam int CPB   = 4;
    localparam int RDL   = 1;
    localparam int LAT   = RDL + 1;
    localparam int FRAME = 10 * CPB;
    localparam int PER   = FRAME + LAT;

    localparam logic [15:0] P_BASE [NI] = '{16'h0010, 16'h0010, 16'hFFFF, 16'h0010};
    localparam int          P_COUNT[NI] = '{1, 3, 2, 0};

    logic        clk;
    logic        rst      [NI];
    logic        start    [NI];
    logic [7:0]  dm_q     [NI];
    logic [15:0] dm_addr  [NI];
    logic        bus_own  [NI];
    logic        uart_tx  [NI];
    logic        busy     [NI];
    logic        done     [NI];

    logic [7:0]  mem [NI][65536];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dram_uart_dumper #(
            .BASE_ADDR    (P_BASE[g]),
            .COUNT        (16'(P_COUNT[g])),
            .CLKS_PER_BIT (16'(CPB)),
            .RD_LAT       (2'(RDL))
        ) u_dut (
            .i_clock   (clk),
            .i_rst     (rst[g]),
            .i_start   (start[g]),
            .i_dm_q    (dm_q[g]),
            .o_dm_addr (dm_addr[g]),
            .o_bus_own (bus_own[g]),
            .o_uart_tx (uart_tx[g]),
            .o_busy    (busy[g]),
            .o_done    (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) dm_q[i] <= mem[i][dm_addr[i]];
    end

    // Model: m_cyc counts cycles since the accepted trigger edge (0 = cycle right after it).
    bit m_act   [NI];
    bit m_sprev [NI];
    int m_cyc   [NI];

    function automatic int m_end(input int i);
        if (P_COUNT[i] == 0) return 0;
        return LAT + (P_COUNT[i] - 1) * PER + FRAME;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                m_act[i]   <= 1'b0;
                m_sprev[i] <= 1'b0;
                m_cyc[i]   <= 0;
            end else begin
                m_sprev[i] <= start[i];
                if (start[i] && !m_sprev[i] && (!m_act[i] || m_cyc[i] > m_end(i))) begin
                    m_act[i] <= 1'b1;
                    m_cyc[i] <= 0;
                end else if (m_act[i] && m_cyc[i] <= m_end(i)) begin
                    m_cyc[i] <= m_cyc[i] + 1;
                end
            end
        end
    end

    // Expected outputs for instance i in the current cycle, from frame arithmetic.
    function automatic void expect_out(input int i, output logic tx, output logic bz,
                                       output logic own, output logic dn, output logic [15:0] ad);
        int m, cnt, r, k, off, b, j;
        logic [15:0] a16;
        logic [7:0]  byt;
        m   = m_cyc[i];
        cnt = P_COUNT[i];
        tx  = 1'b1;
        bz  = 1'b0;
        own = 1'b0;
        dn  = 1'b0;
        ad  = P_BASE[i];
        if (m_act[i] && m <= m_end(i)) begin
            dn = (m == m_end(i));
            if (cnt > 0) begin
                bz  = 1'b1;
                own = 1'b1;
                j = (m >= LAT + FRAME) ? ((m - LAT - FRAME) / PER + 1) : 0;
                if (j > cnt - 1) j = cnt - 1;
                ad = P_BASE[i] + 16'(j);
                r = m - LAT;
                if (r >= 0) begin
                    k   = r / PER;
                    off = r % PER;
                    if (k < cnt && off < FRAME) begin
                        b = off / CPB;
                        if (b == 0) begin
                            tx = 1'b0;
                        end else if (b <= 8) begin
                            a16 = P_BASE[i] + 16'(k);
                            byt = mem[i][a16];
                            tx  = byt[b-1];
                        end
                    end
                end
            end
        end
    endfunction

    // UART decoder: mid-bit sampling, pushes {instance, byte} per received frame.
    bit          mon_act  [NI];
    int          mon_c    [NI];
    logic [7:0]  mon_byte [NI];
    int          mon_ferr [NI];
    logic [15:0] mon_q [$];
    int          done_cnt [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                mon_act[i] <= 1'b0;
            end else if (!mon_act[i]) begin
                if (uart_tx[i] === 1'b0) begin
                    mon_act[i] <= 1'b1;
                    mon_c[i]   <= 1;
                end
            end else begin
                mon_c[i] <= mon_c[i] + 1;
                if (mon_c[i] % CPB == CPB / 2) begin
                    if (mon_c[i] / CPB >= 1 && mon_c[i] / CPB <= 8) begin
                        mon_byte[i][mon_c[i] / CPB - 1] <= uart_tx[i];
                    end else if (mon_c[i] / CPB == 9) begin
                        if (uart_tx[i] !== 1'b1) mon_ferr[i] <= mon_ferr[i] + 1;
                        mon_q.push_back({8'(i), mon_byte[i]});
                        mon_act[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic cmp(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, inst, cyc, act, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then compare every instance to the model.
    task automatic tick();
        logic etx, ebz, eown, edn;
        logic [15:0] ead;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                expect_out(i, etx, ebz, eown, edn, ead);
                cmp("uart_tx", i, 16'(uart_tx[i]), 16'(etx));
                cmp("busy",    i, 16'(busy[i]),    16'(ebz));
                cmp("bus_own", i, 16'(bus_own[i]), 16'(eown));
                cmp("done",    i, 16'(done[i]),    16'(edn));
                cmp("dm_addr", i, dm_addr[i],      ead);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int rd_ptr = 0;

    // Drains decoded bytes and compares this instance's bytes against a literal list.
    task automatic check_bytes(input string nm, input int inst, input int n, input logic [63:0] exp);
        int got;
        logic [15:0] e;
        got = 0;
        while (rd_ptr < mon_q.size()) begin
            e = mon_q[rd_ptr];
            rd_ptr++;
            if (int'(e[15:8]) == inst) begin
                if (got < n) cmp(nm, inst, 16'(e[7:0]), 16'(exp[8*got +: 8]));
                got++;
            end
        end
        cmp({nm, "_count"}, inst, 16'(got), 16'(n));
    endtask

    task automatic pulse(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < NI; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b0;
        end
        mem[0][16'h0010] = 8'hA5;
        mem[1][16'h0010] = 8'h01;
        mem[1][16'h0011] = 8'h80;
        mem[1][16'h0012] = 8'hFF;
        mem[2][16'hFFFF] = 8'h3C;
        mem[2][16'h0000] = 8'hC3;

        run(3);
        chk_en = 1'b1;
        tick();
        cmp("rst_tx",   0, 16'(uart_tx[0]), 16'd1);
        cmp("rst_busy", 1, 16'(busy[1]),    16'd0);
        cmp("rst_addr", 2, dm_addr[2],      16'hFFFF);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        run(2);

        // Single byte A5: first start bit two edges after the trigger edge.
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        k = 1;
        while (uart_tx[0] !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        cmp("t1_first_low", 0, 16'(k), 16'd3);
        run(PER + 10);
        check_bytes("t1_bytes", 0, 1, 64'hA5);
        cmp("t1_done_cnt", 0, 16'(done_cnt[0]), 16'd1);
        cmp("t1_addr",     0, dm_addr[0],       16'h0010);
        cmp("t1_busy",     0, 16'(busy[0]),     16'd0);

        // Three bytes back to back.
        pulse(1);
        run(3 * PER + 10);
        check_bytes("t2_bytes", 1, 3, 64'hFF_80_01);
        cmp("t2_done_cnt", 1, 16'(done_cnt[1]), 16'd1);

        // Address wrap from FFFF to 0000.
        pulse(2);
        run(48);
        cmp("t3_wrap_addr", 2, dm_addr[2], 16'h0000);
        run(PER + 10);
        check_bytes("t3_bytes", 2, 2, 64'hC3_3C);
        cmp("t3_done_cnt", 2, 16'(done_cnt[2]), 16'd1);
        cmp("t3_addr_back", 2, dm_addr[2], 16'hFFFF);

        // COUNT=0: immediate done, line stays idle.
        pulse(3);
        run(10);
        cmp("t4_done_cnt", 3, 16'(done_cnt[3]), 16'd1);
        check_bytes("t4_bytes", 3, 0, 64'h0);

        // Start held high with extra edges while busy: one dump only.
        start[1] = 1'b1;
        tick();
        run(20);
        start[1] = 1'b0;
        tick();
        start[1] = 1'b1;
        run(40);
        start[1] = 1'b0;
        tick();
        start[1] = 1'b1;
        run(3 * PER);
        check_bytes("t5_bytes", 1, 3, 64'hFF_80_01);
        cmp("t5_done_cnt", 1, 16'(done_cnt[1]), 16'd2);
        start[1] = 1'b0;
        run(2);
        pulse(1);
        run(3 * PER + 10);
        check_bytes("t5_retrig", 1, 3, 64'hFF_80_01);
        cmp("t5_done_cnt2", 1, 16'(done_cnt[1]), 16'd3);

        // Reset during data bit 3 of the second byte, then a clean dump.
        pulse(1);
        run(61);
        rst[1] = 1'b1;
        tick();
        cmp("t6_tx",   1, 16'(uart_tx[1]), 16'd1);
        cmp("t6_busy", 1, 16'(busy[1]),    16'd0);
        cmp("t6_own",  1, 16'(bus_own[1]), 16'd0);
        cmp("t6_addr", 1, dm_addr[1],      16'h0010);
        tick();
        rst[1] = 1'b0;
        run(5);
        cmp("t6_no_done", 1, 16'(done_cnt[1]), 16'd3);
        check_bytes("t6_partial", 1, 1, 64'h01);
        pulse(1);
        run(3 * PER + 10);
        check_bytes("t6_bytes", 1, 3, 64'hFF_80_01);
        cmp("t6_done_cnt", 1, 16'(done_cnt[1]), 16'd4);

        for (int i = 0; i < NI; i++) cmp("stop_bit", i, 16'(mon_ferr[i]), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
